// File: rtl/freq_gen_pkg.sv
// Shared width constant and divisor type for the programmable clock divider.
package freq_gen_pkg;

  localparam int unsigned DataWidth = 8;

  typedef logic [DataWidth-1:0] div_t;

endpackage

// File: rtl/freq_gen_counter.sv
// Half-period counter: counts 0..div_i-1 and pulses tc_o on the last count.
module freq_gen_counter
  import freq_gen_pkg::*;
#(
  parameter int unsigned Width = DataWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] div_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             running;

  assign running = (div_i != '0);
  assign tc_o    = running && (cnt_q == div_i - Width'(1));

  // Idle and terminal count both clear, so cnt_q never exceeds div_i-1.
  always_comb begin
    cnt_d = cnt_q;
    if (!running || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/freq_gen_core.sv
// Glitch-free programmable divider: 50% duty clk_out with half-period freq_sel,
// divisor reloaded only at the end of a full period.
module freq_gen_core
  import freq_gen_pkg::*;
#(
  parameter int unsigned DataWidth = freq_gen_pkg::DataWidth
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [DataWidth-1:0] freq_sel,
  output logic                 clk_out
);

  logic [DataWidth-1:0] div_q, div_d;
  logic                 clk_out_q, clk_out_d;
  logic                 tc;
  logic                 idle;

  freq_gen_counter #(
    .Width (DataWidth)
  ) u_counter (
    .clk_i  (clk_in),
    .rst_ni (rst),
    .div_i  (div_q),
    .tc_o   (tc)
  );

  assign idle = (div_q == '0);

  always_comb begin
    div_d     = div_q;
    clk_out_d = clk_out_q;
    if (idle) begin
      div_d     = freq_sel;
      clk_out_d = 1'b0;
    end else if (tc) begin
      clk_out_d = ~clk_out_q;
      // Falling toggle closes the full period: the only place the divisor may change.
      if (clk_out_q) begin
        div_d = freq_sel;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_freq_gen_core.sv
// Randomised and directed bench for freq_gen_core against a period-position model.
module tb_freq_gen_core;
  import freq_gen_pkg::*;

  logic clk_in;
  logic rst;
  div_t freq_sel;
  logic clk_out;

  int n_checks;
  int n_fail;

  // Reference model: position within the current full period of 2*div cycles.
  int   m_div;
  int   m_pos;
  logic m_out;

  freq_gen_core #(
    .DataWidth (8)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .freq_sel (freq_sel),
    .clk_out  (clk_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      m_div <= 0;
      m_pos <= 0;
      m_out <= 1'b0;
    end else if (m_div == 0) begin
      m_div <= int'(freq_sel);
      m_pos <= 0;
      m_out <= 1'b0;
    end else if (m_pos + 1 == 2 * m_div) begin
      m_pos <= 0;
      m_out <= 1'b0;
      m_div <= int'(freq_sel);
    end else begin
      m_pos <= m_pos + 1;
      if (m_pos + 1 == m_div) m_out <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input int n);
    int exp_cnt;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      check_eq("clk_out", int'(clk_out), int'(m_out));
      exp_cnt = (m_div == 0) ? 0 : (m_pos % m_div);
      check_eq("cnt", int'(dut.u_counter.cnt_q), exp_cnt);
      if (m_div != 0) check_eq("cnt_bound", int'(dut.u_counter.cnt_q < 8'(m_div)), 1);
    end
  endtask

  task automatic wait_model_high(input int budget);
    int k;
    k = 0;
    while (m_out !== 1'b1 && k < budget) begin
      run(1);
      k++;
    end
    check_eq("wait_high_timeout", int'(m_out === 1'b1), 1);
  endtask

  initial begin
    int dur;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    freq_sel = 8'd8;

    repeat (3) begin
      @(negedge clk_in);
      check_eq("reset_out", int'(clk_out), 0);
    end
    rst = 1'b1;

    // First rise 9 edges after release for N=8: low for edges 1..8.
    run(8);
    check_eq("first_rise_not_early", int'(clk_out), 0);
    run(1);
    check_eq("first_rise", int'(clk_out), 1);
    run(40);

    // 8 -> 4 during the high phase.
    wait_model_high(40);
    freq_sel = 8'd4;
    run(40);

    freq_sel = 8'd2;
    run(20);
    freq_sel = 8'd1;
    run(10);
    freq_sel = 8'd0;
    run(20);
    check_eq("stopped_low", int'(clk_out), 0);
    freq_sel = 8'd3;
    run(20);

    // Asynchronous reset in the high phase.
    wait_model_high(20);
    @(posedge clk_in);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_out", int'(clk_out), 0);
    freq_sel = 8'd2;
    @(negedge clk_in);
    rst = 1'b1;
    run(2);
    check_eq("rst_restart_low", int'(clk_out), 0);
    run(1);
    check_eq("rst_restart_rise", int'(clk_out), 1);
    run(10);

    // Maximum period.
    freq_sel = 8'd255;
    run(1100);

    // Random divisor changes at random times.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) freq_sel = 8'd0;
      else if ($urandom_range(0, 9) == 0) freq_sel = 8'($urandom_range(20, 255));
      else freq_sel = 8'($urandom_range(1, 9));
      dur = int'($urandom_range(1, 40));
      run(dur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
